// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling from a fixed clocks-per-baud divider.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err strobe.
module uart_rx #(
  parameter int unsigned BW              = 8,
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_uart_rx,
  output logic          o_wr,
  output logic [BW-1:0] o_data,
  output logic          o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic          o_parity_err,
`endif
  output logic          o_busy
);

  localparam int unsigned   IW        = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [23:0]   HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0]   FULL_LOAD = CLOCKS_PER_BAUD - 24'd1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(BW - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state, state_d;
  logic            sync_meta, rx_s;
  logic [23:0]     baud_cnt, cnt_d;
  logic [IW-1:0]   bit_idx, idx_d;
  logic [BW-1:0]   shift_reg, shift_d;
  logic [BW-1:0]   data_d;
  logic            wr_d, ferr_d, busy_d;
  logic            tick;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_d, perr_d;
`endif

  // Two-flop synchronizer; presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= i_uart_rx;
      rx_s      <= sync_meta;
    end
  end

  assign tick = (baud_cnt == 24'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= WAIT_HIGH;
      baud_cnt    <= 24'd0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_data      <= '0;
      o_wr        <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      baud_cnt    <= cnt_d;
      bit_idx     <= idx_d;
      shift_reg   <= shift_d;
      o_data      <= data_d;
      o_wr        <= wr_d;
      o_frame_err <= ferr_d;
      o_busy      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_d;
      o_parity_err <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = baud_cnt;
    idx_d   = bit_idx;
    shift_d = shift_reg;
    data_d  = o_data;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = o_busy;
`ifdef UART_RX_PARITY_EN
    par_d   = par_bit;
    perr_d  = 1'b0;
`endif

    case (state)
      // Busy is held through WAIT_HIGH so a break after a frame error still reads as busy.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          busy_d  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = baud_cnt - 24'd1;
        end
      end

      DATA: begin
        if (tick) begin
          shift_d[bit_idx] = rx_s;
          cnt_d            = FULL_LOAD;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = bit_idx + IW'(1);
          end
        end else begin
          cnt_d = baud_cnt - 24'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_s;
          cnt_d   = FULL_LOAD;
          state_d = STOP;
        end else begin
          cnt_d = baud_cnt - 24'd1;
        end
      end
`endif

      // IDLE is re-entered at mid-stop so a back-to-back start edge is not missed.
      STOP: begin
        if (tick) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            if ((^shift_reg) == par_bit) begin
              data_d = shift_reg;
              wr_d   = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
`else
            data_d = shift_reg;
            wr_d   = 1'b1;
`endif
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = baud_cnt - 24'd1;
        end
      end

      default: begin
        state_d = WAIT_HIGH;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level event model.
// Honours UART_RX_PARITY_EN when the design is built with it.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BW  = 8;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Stop-bit sample lands (BW + 1.5 + parity) bit times after the start edge.
  localparam int LAT_BASE = ((2 * BW + 3 + 2 * PBITS) * CPB) / 2;

  localparam int EV_WR   = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_uart_rx;
  logic          o_wr;
  logic [BW-1:0] o_data;
  logic          o_frame_err;
  logic          o_busy;
  logic          perr;

  uart_rx #(
    .BW(BW),
    .CLOCKS_PER_BAUD(24'(CPB))
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_uart_rx(i_uart_rx),
    .o_wr(o_wr),
    .o_data(o_data),
    .o_frame_err(o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(perr),
`endif
    .o_busy(o_busy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  typedef struct {
    int            kind;
    logic [BW-1:0] data;
    int            start;
  } ev_t;

  ev_t           expq[$];
  logic [BW-1:0] model_data = '0;
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;
  logic          rst_at_pos = 1'b0;
  logic          checking = 1'b0;
  int            wr_count = 0;
  int            ferr_count = 0;
  int            perr_count = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge i_clk) begin
    cyc        <= cyc + 1;
    rst_at_pos <= i_rst_n;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Every cycle: outputs must match the event model, events arrive in order with spec latency.
  always @(negedge i_clk) begin
    ev_t ev;
    int  kind;
    if (!rst_at_pos) begin
      model_data = '0;
      expq.delete();
    end else if (checking) begin
      checkOutput("wr_ferr_exclusive", {31'd0, o_wr & o_frame_err}, 32'd0);
      if (o_wr || o_frame_err || perr) begin
        kind = o_wr ? EV_WR : (o_frame_err ? EV_FERR : EV_PERR);
        if (o_wr) wr_count++;
        if (o_frame_err) ferr_count++;
        if (perr) perr_count++;
        checkOutput("event_expected", {31'd0, expq.size() > 0}, 32'd1);
        if (expq.size() > 0) begin
          ev = expq.pop_front();
          checkOutput("event_kind", 32'(kind), 32'(ev.kind));
          checkRange("event_latency", cyc - ev.start, LAT_BASE + 2, LAT_BASE + 3);
          if (ev.kind == EV_WR) model_data = ev.data;
        end
      end
      checkOutput("o_data_model", 32'(o_data), 32'(model_data));
    end
  end

  task automatic driveBit(input logic b);
    i_uart_rx = b;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic applyReset(input int cycles);
    i_rst_n = 1'b0;
    repeat (cycles) @(negedge i_clk);
    checkOutput("reset_o_wr", {31'd0, o_wr}, 32'd0);
    checkOutput("reset_o_data", 32'(o_data), 32'd0);
    checkOutput("reset_o_frame_err", {31'd0, o_frame_err}, 32'd0);
    checkOutput("reset_o_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset_o_parity_err", {31'd0, perr}, 32'd0);
    i_rst_n = 1'b1;
  endtask

  // One frame; abort_bit >= 0 asserts reset halfway through that data bit.
  task automatic applyStimulus(input logic [BW-1:0] d, input logic stop_ok, input logic par_ok,
                               input int break_bits, input int abort_bit);
    ev_t ev;
    ev.data  = d;
    ev.start = cyc;
    if (!stop_ok) ev.kind = EV_FERR;
    else if (PBITS == 1 && !par_ok) ev.kind = EV_PERR;
    else ev.kind = EV_WR;
    if (abort_bit < 0) expq.push_back(ev);
    driveBit(1'b0);
    for (int i = 0; i < BW; i++) begin
      if (i == 4) checkOutput("busy_mid_frame", {31'd0, o_busy}, 32'd1);
      if (i == abort_bit) begin
        i_uart_rx = d[i];
        repeat (CPB / 2) @(negedge i_clk);
        applyReset(3);
        i_uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge i_clk);
        return;
      end
      driveBit(d[i]);
    end
    if (PBITS == 1) driveBit((^d) ^ ~par_ok);
    driveBit(stop_ok);
    if (!stop_ok) begin
      repeat (break_bits) driveBit(1'b0);
      driveBit(1'b1);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 4 * LAT_BASE) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput(name, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int w0, f0, p0, busy_cnt;
    logic [BW-1:0] rb;
    logic          rs, rp;

    i_rst_n   = 1'b0;
    i_uart_rx = 1'b1;
    @(negedge i_clk);
    applyReset(4);
    checking = 1'b1;
    repeat (4) @(negedge i_clk);

    // Single 0xA5 frame.
    w0 = wr_count; f0 = ferr_count;
    applyStimulus(8'hA5, 1'b1, 1'b1, 0, -1);
    driveBit(1'b1);
    waitDrain("drain_a5");
    checkOutput("lit_a5_data", 32'(o_data), 32'h0000_00A5);
    checkOutput("lit_a5_wr_count", 32'(wr_count - w0), 32'd1);
    checkOutput("lit_a5_no_ferr", 32'(ferr_count - f0), 32'd0);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    w0 = wr_count;
    applyStimulus(8'h00, 1'b1, 1'b1, 0, -1);
    applyStimulus(8'hFF, 1'b1, 1'b1, 0, -1);
    driveBit(1'b1);
    waitDrain("drain_b2b");
    checkOutput("lit_b2b_wr_count", 32'(wr_count - w0), 32'd2);
    checkOutput("lit_b2b_last", 32'(o_data), 32'h0000_00FF);

    // Five-clock glitch must be rejected at the start-bit sample.
    w0 = wr_count; f0 = ferr_count; busy_cnt = 0;
    i_uart_rx = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      busy_cnt += int'(o_busy);
    end
    i_uart_rx = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      busy_cnt += int'(o_busy);
    end
    checkRange("glitch_busy_cycles", busy_cnt, 7, 9);
    checkOutput("glitch_busy_end", {31'd0, o_busy}, 32'd0);
    checkOutput("glitch_no_events", 32'((wr_count - w0) + (ferr_count - f0)), 32'd0);

    // Bad stop bit followed by a 40-bit break, then 0x81.
    w0 = wr_count; f0 = ferr_count;
    applyStimulus(8'h3C, 1'b0, 1'b1, 40, -1);
    driveBit(1'b1);
    applyStimulus(8'h81, 1'b1, 1'b1, 0, -1);
    driveBit(1'b1);
    waitDrain("drain_break");
    checkOutput("lit_break_ferr_count", 32'(ferr_count - f0), 32'd1);
    checkOutput("lit_break_wr_count", 32'(wr_count - w0), 32'd1);
    checkOutput("lit_break_data", 32'(o_data), 32'h0000_0081);

    // Reset during data bit 3, then 0x5A.
    w0 = wr_count;
    applyStimulus(8'hC3, 1'b1, 1'b1, 0, 3);
    applyStimulus(8'h5A, 1'b1, 1'b1, 0, -1);
    driveBit(1'b1);
    waitDrain("drain_abort");
    checkOutput("lit_abort_wr_count", 32'(wr_count - w0), 32'd1);
    checkOutput("lit_abort_data", 32'(o_data), 32'h0000_005A);

`ifdef UART_RX_PARITY_EN
    // Good then bad even parity on 0x07.
    w0 = wr_count; p0 = perr_count;
    applyStimulus(8'h07, 1'b1, 1'b1, 0, -1);
    applyStimulus(8'h07, 1'b1, 1'b0, 0, -1);
    driveBit(1'b1);
    waitDrain("drain_parity");
    checkOutput("lit_parity_wr_count", 32'(wr_count - w0), 32'd1);
    checkOutput("lit_parity_err_count", 32'(perr_count - p0), 32'd1);
    checkOutput("lit_parity_data", 32'(o_data), 32'h0000_0007);
`else
    p0 = perr_count;
    checkOutput("no_parity_err", 32'(perr_count - p0), 32'd0);
`endif

    // Randomized traffic: random bytes, occasional bad stop/parity, random idle gaps.
    for (int n = 0; n < 40; n++) begin
      rb = BW'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      rp = ($urandom_range(0, 5) != 0);
      applyStimulus(rb, rs, rp, int'($urandom_range(0, 2)), -1);
      repeat ($urandom_range(0, 2)) driveBit(1'b1);
    end
    driveBit(1'b1);
    waitDrain("drain_random");

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
